// File: rtl/ser_8b10b_tx.sv
// 8b/10b (IEEE 802.3 Clause 36) encoder and serializer with K28.5 idle fill.
// Define SER_PRBS7_EN to add the prbs_en input and a PRBS7 line test pattern.
module ser_8b10b_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_8b,
    input  logic       in_k,
    input  logic       in_valid,
`ifdef SER_PRBS7_EN
    input  logic       prbs_en,
`endif
    output logic       in_ready,
    output logic       ser_out,
    output logic       word_start,
    output logic       code_err,
    output logic       rd_out
);

    localparam logic [7:0] K28_5 = 8'hBC;

    logic [7:0] hold_8b;
    logic       hold_k;
    logic       hold_valid;
    logic [9:0] sr;
    logic [3:0] bit_cnt;
    logic       rd;
    logic       prbs_act;
    logic       boundary;

    logic [7:0] chr_8b;
    logic       chr_k;
    logic       chr_bad;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd_mid;
    logic       a7;
    logic [9:0] grp;
    logic       grp_rd;

    // Returns {abcdei, rd after sub-block}; table holds the RD- form.
    function automatic logic [6:0] enc_6b(input logic [4:0] x, input logic k28, input logic rd_in);
        logic [5:0] c;
        logic       unbal;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        if (k28)
            c = 6'b001111;
        unbal = ($countones(c) != 3);
        // D.7 is balanced but still has distinct RD-/RD+ forms
        if (rd_in && (unbal || (x == 5'd7 && !k28)))
            c = ~c;
        return {c, rd_in ^ unbal};
    endfunction

    // Returns {fghj, rd after sub-block}; table holds the RD- data form.
    function automatic logic [4:0] enc_4b(input logic [2:0] y, input logic k, input logic alt7,
                                          input logic rd_in);
        logic [3:0] c;
        logic       flip;
        logic       unbal;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = alt7 ? 4'b0111 : 4'b1110;
        endcase
        flip  = (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
        unbal = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
        // Balanced K sub-blocks alternate with RD so commas stay unique
        if (k && !flip)
            c = rd_in ? c : ~c;
        else if (rd_in && flip)
            c = ~c;
        return {c, rd_in ^ unbal};
    endfunction

    function automatic logic k_legal(input logic [7:0] b);
        logic [4:0] x;
        x = b[4:0];
        return (x == 5'd28) ||
               ((b[7:5] == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    endfunction

`ifdef SER_PRBS7_EN
    logic [6:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= 7'h7F;
        else
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    assign prbs_act = prbs_en;
    assign ser_out  = prbs_en ? lfsr[6] : sr[9];
`else
    assign prbs_act = 1'b0;
    assign ser_out  = sr[9];
`endif

    assign boundary = (bit_cnt == 4'd9);
    assign in_ready = !hold_valid && !prbs_act;
    assign rd_out   = rd;

    always_comb begin
        chr_8b = K28_5;
        chr_k  = 1'b1;
        if (hold_valid && !prbs_act) begin
            chr_8b = hold_8b;
            chr_k  = hold_k;
        end
        chr_bad = chr_k && !k_legal(chr_8b);
        if (chr_bad)
            chr_8b = K28_5;
        {c6, rd_mid} = enc_6b(chr_8b[4:0], chr_k && (chr_8b[4:0] == 5'd28), rd);
        a7 = chr_k || ((chr_8b[7:5] == 3'd7) &&
             (rd_mid ? (chr_8b[4:0] == 5'd11 || chr_8b[4:0] == 5'd13 || chr_8b[4:0] == 5'd14)
                     : (chr_8b[4:0] == 5'd17 || chr_8b[4:0] == 5'd18 || chr_8b[4:0] == 5'd20)));
        {c4, grp_rd} = enc_4b(chr_8b[7:5], chr_k, a7, rd_mid);
        grp = {c6, c4};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_8b    <= 8'h00;
            hold_k     <= 1'b0;
            hold_valid <= 1'b0;
        end else if (boundary && hold_valid && !prbs_act) begin
            hold_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            hold_8b    <= in_8b;
            hold_k     <= in_k;
            hold_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= 10'b0;
            bit_cnt    <= 4'd9;
            rd         <= 1'b0;
            word_start <= 1'b0;
            code_err   <= 1'b0;
        end else if (boundary) begin
            sr         <= grp;
            bit_cnt    <= 4'd0;
            rd         <= prbs_act ? rd : grp_rd;
            word_start <= 1'b1;
            code_err   <= chr_bad;
        end else begin
            sr         <= {sr[8:0], 1'b0};
            bit_cnt    <= bit_cnt + 4'd1;
            word_start <= 1'b0;
            code_err   <= 1'b0;
        end
    end

endmodule
